tm_feedback_update: RTL and testbench



---
 rtl/tm_feedback_update.sv | 88 ++++++++
 tb/tb_tm_feedback_update.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tm_feedback_update.sv
// Tsetlin-machine feedback update: saturating clause-weight increment and literal automaton reward/penalty.
// Latency: one cycle, inputs are registered into weight_out/state_out on the rising clk edge when en=1.
// Backpressure: none; en=0 freezes outputs and the internal LFSR, and rst_n (synchronous) overrides en.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   en                  update enable
//   conjunction_result  per-clause fire bits; a firing clause gets its weight bumped
//   actions, literals   per-literal include/exclude action and sample value
//   weight_in/out       packed clause weights, clause i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   state_in/out        packed literal states, literal j at [j*STATE_WIDTH +: STATE_WIDTH]
module tm_feedback_update #(
  parameter int CLAUSE_NUM   = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int STATE_WIDTH  = 8,
  parameter int LITERAL_NUM  = 8,
  parameter int LFSR_WIDTH   = 24,
  // Tap mask for the Fibonacci feedback; default is x^24+x^23+x^22+x^17+1
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS = LFSR_WIDTH'(24'hE1_0000)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic [CLAUSE_NUM-1:0]               conjunction_result,
  input  logic [LITERAL_NUM-1:0]              actions,
  input  logic [LITERAL_NUM-1:0]              literals,
  input  logic [CLAUSE_NUM*WEIGHT_WIDTH-1:0]  weight_in,
  output logic [CLAUSE_NUM*WEIGHT_WIDTH-1:0]  weight_out,
  input  logic [LITERAL_NUM*STATE_WIDTH-1:0]  state_in,
  output logic [LITERAL_NUM*STATE_WIDTH-1:0]  state_out
);

  localparam logic [WEIGHT_WIDTH-1:0] W_MAX = {WEIGHT_WIDTH{1'b1}};
  localparam logic [STATE_WIDTH-1:0]  S_MAX = {STATE_WIDTH{1'b1}};
  localparam logic [STATE_WIDTH-1:0]  S_MIN = {STATE_WIDTH{1'b0}};

  logic [CLAUSE_NUM*WEIGHT_WIDTH-1:0] weight_nxt;
  logic [LITERAL_NUM*STATE_WIDTH-1:0] state_nxt;
  logic [LFSR_WIDTH-1:0]              lfsr;
  logic                               lfsr_fb;

  // Weight lanes: increment on fire, pinned at all-ones
  always_comb begin
    weight_nxt = weight_in;
    for (int i = 0; i < CLAUSE_NUM; i++) begin
      if (conjunction_result[i] && (weight_in[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != W_MAX)) begin
        weight_nxt[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
          weight_in[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] + WEIGHT_WIDTH'(1);
      end
    end
  end

  // State lanes: literal and action agreeing on 1 rewards, agreeing on 0 penalises,
  // disagreement leaves the automaton where it is
  always_comb begin
    state_nxt = state_in;
    for (int j = 0; j < LITERAL_NUM; j++) begin
      if (literals[j] && actions[j]) begin
        if (state_in[j*STATE_WIDTH +: STATE_WIDTH] != S_MAX) begin
          state_nxt[j*STATE_WIDTH +: STATE_WIDTH] =
            state_in[j*STATE_WIDTH +: STATE_WIDTH] + STATE_WIDTH'(1);
        end
      end else if (!literals[j] && !actions[j]) begin
        if (state_in[j*STATE_WIDTH +: STATE_WIDTH] != S_MIN) begin
          state_nxt[j*STATE_WIDTH +: STATE_WIDTH] =
            state_in[j*STATE_WIDTH +: STATE_WIDTH] - STATE_WIDTH'(1);
        end
      end
    end
  end

  // XOR of the tapped bits; seeded non-zero, so the sequence never collapses to zero
  assign lfsr_fb = ^(lfsr & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      weight_out <= '0;
      state_out  <= '0;
      lfsr       <= LFSR_WIDTH'(1);
    end else if (en) begin
      weight_out <= weight_nxt;
      state_out  <= state_nxt;
      // Reserved for stochastic feedback gating; not yet consumed
      lfsr       <= {lfsr[LFSR_WIDTH-2:0], lfsr_fb};
    end
  end

endmodule

// File: tb/tb_tm_feedback_update.sv
// Bench for tm_feedback_update: directed spec cases plus randomized traffic.
// A driver pushes the model's expected outputs into a queue; a monitor pops after each edge.
module tb_tm_feedback_update;

  localparam int CN = 4;
  localparam int WW = 8;
  localparam int SW = 8;
  localparam int LN = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic [CN-1:0]        conjunction_result;
  logic [LN-1:0]        actions;
  logic [LN-1:0]        literals;
  logic [CN*WW-1:0]     weight_in;
  logic [CN*WW-1:0]     weight_out;
  logic [LN*SW-1:0]     state_in;
  logic [LN*SW-1:0]     state_out;

  int n_vec  = 0;
  int n_fail = 0;

  // Model's view of the output registers and the pending expected values
  logic [CN*WW-1:0]     mw;
  logic [LN*SW-1:0]     ms;
  logic [CN*WW+LN*SW-1:0] exp_q[$];

  tm_feedback_update #(
    .CLAUSE_NUM(CN), .WEIGHT_WIDTH(WW), .STATE_WIDTH(SW), .LITERAL_NUM(LN), .LFSR_WIDTH(24)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .conjunction_result(conjunction_result),
    .actions(actions),
    .literals(literals),
    .weight_in(weight_in),
    .weight_out(weight_out),
    .state_in(state_in),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus, predict the registered result, and wait past the edge
  task automatic drive(input logic r, input logic e, input logic [CN-1:0] c,
                       input logic [LN-1:0] a, input logic [LN-1:0] l,
                       input logic [CN*WW-1:0] w, input logic [LN*SW-1:0] s);
    int v;
    rst_n = r; en = e; conjunction_result = c; actions = a; literals = l;
    weight_in = w; state_in = s;
    if (!r) begin
      mw = '0;
      ms = '0;
    end else if (e) begin
      for (int i = 0; i < CN; i++) begin
        v = int'(w[i*WW +: WW]);
        if (c[i]) v = (v + 1 > 255) ? 255 : v + 1;
        mw[i*WW +: WW] = WW'(v);
      end
      for (int j = 0; j < LN; j++) begin
        v = int'(s[j*SW +: SW]);
        if (l[j] && a[j])        v = (v + 1 > 255) ? 255 : v + 1;
        else if (!l[j] && !a[j]) v = (v - 1 < 0) ? 0 : v - 1;
        s[j*SW +: SW] = s[j*SW +: SW];
        ms[j*SW +: SW] = SW'(v);
      end
    end
    exp_q.push_back({mw, ms});
    @(negedge clk);
  endtask

  // Direct check against constants taken from the specification's test plan
  task automatic check_now(input string name, input logic [CN*WW-1:0] ew, input logic [LN*SW-1:0] es);
    n_vec++;
    if (weight_out !== ew || state_out !== es) begin
      n_fail++;
      $display("FAIL %s: got weight_out=%h state_out=%h, want weight_out=%h state_out=%h",
               name, weight_out, state_out, ew, es);
    end
  endtask

  // Monitor: one expected entry per clock edge
  initial begin
    logic [CN*WW+LN*SW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({weight_out, state_out} !== e) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: got w=%h s=%h, want w=%h s=%h", $time,
                   weight_out, state_out, e[CN*WW+LN*SW-1 -: CN*WW], e[LN*SW-1:0]);
        end
      end
    end
  end

  function automatic logic [7:0] rbyte();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'($urandom_range(0, 1) ? 8'h01 : 8'hFE);
      default: return 8'($urandom);
    endcase
  endfunction

  localparam logic [3:0]  NC = 4'b1010;
  localparam logic [7:0]  NA = 8'b11001100;
  localparam logic [7:0]  NL = 8'b10101010;
  localparam logic [31:0] NW = 32'h01020304;
  localparam logic [63:0] NS = 64'h0102030405060708;
  localparam logic [31:0] RW = 32'h02020404;
  localparam logic [63:0] RS = 64'h0202030306060707;

  initial begin
    logic [CN*WW-1:0] w;
    logic [LN*SW-1:0] s;
    int guard;
    mw = '0;
    ms = '0;

    // Nominal: reset one cycle, then two enabled edges
    drive(1'b0, 1'b1, NC, NA, NL, NW, NS);
    check_now("reset_state", 32'h0, 64'h0);
    drive(1'b1, 1'b1, NC, NA, NL, NW, NS);
    check_now("nominal_latency", RW, RS);
    drive(1'b1, 1'b1, NC, NA, NL, NW, NS);
    check_now("nominal", RW, RS);

    // Reset overrides en, then outputs update one cycle after release
    drive(1'b0, 1'b1, NC, NA, NL, NW, NS);
    check_now("reset_over_en", 32'h0, 64'h0);
    drive(1'b1, 1'b1, NC, NA, NL, NW, NS);
    check_now("after_reset", RW, RS);

    // Hold with inputs changed
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 4'hF, 8'hFF, 8'hFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
      check_now("hold", RW, RS);
    end

    // Saturation high and low
    drive(1'b1, 1'b1, 4'hF, 8'hFF, 8'hFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    check_now("sat_high", 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    drive(1'b1, 1'b1, 4'h0, 8'h00, 8'h00, 32'h05060708, 64'h0);
    check_now("sat_low", 32'h05060708, 64'h0);

    // Non-accumulation over five enabled edges
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, NC, NA, NL, NW, NS);
      check_now("non_accum", RW, RS);
    end

    // Randomized traffic with boundary-biased lane values, occasional reset and stalls
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < CN; i++) w[i*WW +: WW] = rbyte();
      for (int j = 0; j < LN; j++) s[j*SW +: SW] = rbyte();
      drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
            CN'($urandom), LN'($urandom), LN'($urandom), w, s);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d expected entries never checked, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
